// File: rtl/seg7_scan_driver_pkg.sv
// Purpose: shared types, segment constants and the BCD-to-segment table for the scan driver.
// Latency: none (types and a pure function only).
// Backpressure: none.
package seg7_pkg;

    // Segment vector ordered {g,f,e,d,c,b,a}; active-low, so 0 lights a segment
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;

    // Common-anode pattern for a BCD digit; any non-BCD code shows a dash
    function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
        seg_t seg;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Purpose: groups the digit inputs and the display pins of the scan driver.
// Latency: none (wiring only).
// Backpressure: none; the display side is free-running.
interface seg7_scan_driver_if;
    import seg7_pkg::*;

    logic [15:0] digits_i;
    logic [3:0]  dp_i;
    seg_t        seg_o;
    logic        dp_o;
    logic [3:0]  an_o;

    // Source of the digits (counter chain / testbench)
    modport master (
        output digits_i, dp_i,
        input  seg_o, dp_o, an_o
    );

    // The scan driver itself
    modport slave (
        input  digits_i, dp_i,
        output seg_o, dp_o, an_o
    );

endinterface

// File: rtl/seg7_scan_driver_decoder.sv
// Purpose: combinational BCD digit to common-anode segment pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output seg_t       o_seg
);

    assign o_seg = bcd_to_seg(i_bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose: 4-digit multiplexed common-anode 7-seg driver with per-slot ghosting guard
//          and once-per-frame input snapshot. Optional macro: LEADING_ZERO_BLANK_EN.
// Latency: outputs registered, lag the scan state by 1 clk; backpressure: none (free-running).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,  // clk cycles per digit slot, >= 2
    parameter int BLANK_CYCLES = 16      // all-off cycles at slot start, 0..REFRESH_DIV-1
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_driver_if.slave   bus
);

    localparam int                CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_pre_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_sh_digits;
    logic [3:0]       r_sh_dp;
    seg_t             r_seg;
    logic [3:0]       r_an;
    logic             r_dp;

    logic             w_tick;
    logic             w_guard;
    logic             w_blank;
    logic [3:0]       w_digit;
    seg_t             w_dec_seg;

    assign w_tick  = (r_pre_cnt == CNT_MAX);
    assign w_digit = r_sh_digits[{r_idx, 2'b00} +: 4];

    // A zero-length guard must not produce a constant compare against zero
    generate
        if (BLANK_CYCLES == 0) begin : g_no_guard
            assign w_guard = 1'b0;
        end else begin : g_guard
            assign w_guard = (r_pre_cnt < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // Blank digit k when it and every digit to its left are zero; digit0 always shows
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd3:    w_blank = (r_sh_digits[15:12] == 4'h0);
            2'd2:    w_blank = (r_sh_digits[15:8]  == 8'h00);
            2'd1:    w_blank = (r_sh_digits[15:4]  == 12'h000);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    seg7_decoder u_dec (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    // Slot prescaler and digit index; idx advances on the last cycle of each slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
            r_idx     <= 2'd0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_pre_cnt <= r_pre_cnt + CNT_W'(1);
        end
    end

    // Capture inputs only at frame end so a frame never mixes old and new digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_digits <= 16'h0000;
            r_sh_dp     <= 4'h0;
        end else if (w_tick && (r_idx == 2'd3)) begin
            r_sh_digits <= bus.digits_i;
            r_sh_dp     <= bus.dp_i;
        end
    end

    // Registered pin drive: all-off during the guard, else one anode plus its digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'hF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (w_guard) begin
            r_an  <= 4'hF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_blank ? SEG_BLANK : w_dec_seg;
            r_dp  <= ~r_sh_dp[r_idx];
        end
    end

    assign bus.an_o  = r_an;
    assign bus.seg_o = r_seg;
    assign bus.dp_o  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose: directed self-checking bench for seg7_scan_driver (REFRESH_DIV=4, BLANK_CYCLES=1 and 0).
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: none.
module tb_seg7_scan_driver;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   edge_n;

    seg7_scan_driver_if bus_a ();
    seg7_scan_driver_if bus_b ();

    seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) u_dut_nog (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected anode per slot and segment patterns for the digit words used below
    localparam logic [3:0] AN_EXP   [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic [6:0] SEG_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    localparam logic [6:0] SEG_5678 [4] = '{7'h00, 7'h78, 7'h02, 7'h12};

    task automatic set_inputs(input logic [15:0] d, input logic [3:0] p);
        bus_a.digits_i = d;
        bus_a.dp_i     = p;
        bus_b.digits_i = d;
        bus_b.dp_i     = p;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        edge_n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        set_inputs(16'h1234, 4'h0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.an_o, bus_a.seg_o, bus_a.dp_o} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL reset_held_a got an=%h seg=%h dp=%b want F 7F 1", bus_a.an_o, bus_a.seg_o, bus_a.dp_o);
        end
        checks++;
        if ({bus_b.an_o, bus_b.seg_o, bus_b.dp_o} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL reset_held_b got an=%h seg=%h dp=%b want F 7F 1", bus_b.an_o, bus_b.seg_o, bus_b.dp_o);
        end
        rst_n  = 1'b1;
        edge_n = 0;
        repeat (6) step();
        // Edge 6 is inside slot 1 of the first frame: digit1 of the zero shadow
        checks++;
        if ({bus_a.an_o, bus_a.seg_o} !== {4'hD, 7'h40}) begin
            errors++;
            $display("FAIL pre_midreset got an=%h seg=%h want D 40", bus_a.an_o, bus_a.seg_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.an_o, bus_a.seg_o, bus_a.dp_o} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL midreset_a got an=%h seg=%h dp=%b want F 7F 1", bus_a.an_o, bus_a.seg_o, bus_a.dp_o);
        end
        checks++;
        if ({bus_b.an_o, bus_b.seg_o, bus_b.dp_o} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL midreset_b got an=%h seg=%h dp=%b want F 7F 1", bus_b.an_o, bus_b.seg_o, bus_b.dp_o);
        end
    endtask

    // Three frames of 1234: frame 0 shows the zero shadow, frames 1-2 show 1234
    task automatic test_scan_and_guard();
        int p, s, f;
        logic [6:0] es;
        set_inputs(16'h1234, 4'h0);
        do_reset();
        for (int e = 1; e <= 48; e++) begin
            step();
            p = (edge_n - 1) % 4;
            s = ((edge_n - 1) / 4) % 4;
            f = (edge_n - 1) / 16;
`ifdef LEADING_ZERO_BLANK_EN
            es = (f == 0) ? ((s == 0) ? 7'h40 : 7'h7F) : SEG_1234[s];
`else
            es = (f == 0) ? 7'h40 : SEG_1234[s];
`endif
            checks++;
            if (p == 0) begin
                if ({bus_a.an_o, bus_a.seg_o, bus_a.dp_o} !== {4'hF, 7'h7F, 1'b1}) begin
                    errors++;
                    $display("FAIL guard e=%0d got an=%h seg=%h dp=%b want F 7F 1", edge_n, bus_a.an_o, bus_a.seg_o, bus_a.dp_o);
                end
            end else if ({bus_a.an_o, bus_a.seg_o, bus_a.dp_o} !== {AN_EXP[s], es, 1'b1}) begin
                errors++;
                $display("FAIL scan e=%0d got an=%h seg=%h dp=%b want %h %h 1", edge_n, bus_a.an_o, bus_a.seg_o, bus_a.dp_o, AN_EXP[s], es);
            end
            checks++;
            if ({bus_b.an_o, bus_b.seg_o, bus_b.dp_o} !== {AN_EXP[s], es, 1'b1}) begin
                errors++;
                $display("FAIL noguard e=%0d got an=%h seg=%h dp=%b want %h %h 1", edge_n, bus_b.an_o, bus_b.seg_o, bus_b.dp_o, AN_EXP[s], es);
            end
        end
    endtask

    // Input changes during slot 1 of frame 1 must not appear until frame 2
    task automatic test_snapshot();
        int p, s, f;
        logic [6:0] es;
        set_inputs(16'h1234, 4'h0);
        do_reset();
        for (int e = 1; e <= 48; e++) begin
            step();
            if (edge_n == 22) set_inputs(16'h5678, 4'h0);
            p = (edge_n - 1) % 4;
            s = ((edge_n - 1) / 4) % 4;
            f = (edge_n - 1) / 16;
            es = (f == 1) ? SEG_1234[s] : SEG_5678[s];
            if (f >= 1 && p != 0) begin
                checks++;
                if ({bus_a.an_o, bus_a.seg_o} !== {AN_EXP[s], es}) begin
                    errors++;
                    $display("FAIL snapshot e=%0d got an=%h seg=%h want %h %h", edge_n, bus_a.an_o, bus_a.seg_o, AN_EXP[s], es);
                end
            end
        end
    endtask

    // Non-BCD digit shows a dash; decimal point follows the snapshot
    task automatic test_bad_bcd_dp();
        int p, s, f;
        logic [3:0] dpv;
`ifdef LEADING_ZERO_BLANK_EN
        logic [6:0] tbl [4] = '{7'h10, 7'h3F, 7'h7F, 7'h7F};
`else
        logic [6:0] tbl [4] = '{7'h10, 7'h3F, 7'h40, 7'h40};
`endif
        dpv = 4'b0010;
        set_inputs(16'h00A9, dpv);
        do_reset();
        for (int e = 1; e <= 32; e++) begin
            step();
            p = (edge_n - 1) % 4;
            s = ((edge_n - 1) / 4) % 4;
            f = (edge_n - 1) / 16;
            if (f == 1 && p != 0) begin
                checks++;
                if ({bus_a.an_o, bus_a.seg_o, bus_a.dp_o} !== {AN_EXP[s], tbl[s], ~dpv[s]}) begin
                    errors++;
                    $display("FAIL bad_bcd e=%0d got an=%h seg=%h dp=%b want %h %h %b", edge_n, bus_a.an_o, bus_a.seg_o, bus_a.dp_o, AN_EXP[s], tbl[s], ~dpv[s]);
                end
            end
        end
    endtask

    // Leading zeros: blanked when the feature is built in, shown otherwise
    task automatic test_leading_zero();
        int p, s, f;
        logic [15:0] pats [2] = '{16'h0040, 16'h0000};
`ifdef LEADING_ZERO_BLANK_EN
        logic [6:0] tbl [2][4] = '{'{7'h40, 7'h19, 7'h7F, 7'h7F}, '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
`else
        logic [6:0] tbl [2][4] = '{'{7'h40, 7'h19, 7'h40, 7'h40}, '{7'h40, 7'h40, 7'h40, 7'h40}};
`endif
        for (int k = 0; k < 2; k++) begin
            set_inputs(pats[k], 4'h0);
            do_reset();
            for (int e = 1; e <= 32; e++) begin
                step();
                p = (edge_n - 1) % 4;
                s = ((edge_n - 1) / 4) % 4;
                f = (edge_n - 1) / 16;
                if (f == 1 && p != 0) begin
                    checks++;
                    if ({bus_a.an_o, bus_a.seg_o} !== {AN_EXP[s], tbl[k][s]}) begin
                        errors++;
                        $display("FAIL lead_zero pat=%h e=%0d got an=%h seg=%h want %h %h", pats[k], edge_n, bus_a.an_o, bus_a.seg_o, AN_EXP[s], tbl[k][s]);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        rst_n  = 1'b0;
        set_inputs(16'h0000, 4'h0);
        test_reset();
        test_scan_and_guard();
        test_snapshot();
        test_bad_bcd_dp();
        test_leading_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
